// File: rtl/time_elapsed.sv
// rtl/time_elapsed.sv - free-running mm:ss stopwatch with 1 Hz prescaler
// Optional build macro TIME_ELAPSED_SATURATE_EN: hold at 59:59 instead of wrapping to 00:00.
module time_elapsed #(
    parameter int TICKS_PER_SEC = 100000000
) (
    output logic [5:0] mm,
    output logic [5:0] ss,
    input  logic       clk,
    input  logic       rst
);

    localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);

    logic [PW-1:0] r_presc;
    logic [5:0]    r_mm;
    logic [5:0]    r_ss;
    logic          w_tick;
    logic          w_sec_wrap;
    logic          w_min_wrap;
    logic          w_hold;

    assign w_tick     = (r_presc == PRESC_LAST);
    assign w_sec_wrap = (r_ss == 6'd59);
    assign w_min_wrap = (r_mm == 6'd59);

`ifdef TIME_ELAPSED_SATURATE_EN
    assign w_hold = w_sec_wrap && w_min_wrap;
`else
    assign w_hold = 1'b0;
`endif

    // The prescaler keeps running even while saturated; only mm/ss freeze.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_presc <= '0;
        end else if (w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ss <= '0;
            r_mm <= '0;
        end else if (w_tick && !w_hold) begin
            if (w_sec_wrap) begin
                r_ss <= '0;
                r_mm <= w_min_wrap ? 6'd0 : r_mm + 6'd1;
            end else begin
                r_ss <= r_ss + 6'd1;
            end
        end
    end

    assign mm = r_mm;
    assign ss = r_ss;

endmodule

// File: tb/tb_time_elapsed.sv
// tb/tb_time_elapsed.sv - scoreboard bench for time_elapsed (TICKS_PER_SEC=4 and 1)
module tb_time_elapsed;

    logic       clk;
    logic       rst;
    logic [5:0] mm4, ss4, mm1, ss1;

    time_elapsed #(.TICKS_PER_SEC(4)) u_dut4 (.mm(mm4), .ss(ss4), .clk(clk), .rst(rst));
    time_elapsed #(.TICKS_PER_SEC(1)) u_dut1 (.mm(mm1), .ss(ss1), .clk(clk), .rst(rst));

    typedef struct {
        string      tag;
        int         at;
        int         tps;
        logic [5:0] mm;
        logic [5:0] ss;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   edge_cnt = 0;

    initial begin
        #2;
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic void model(input int edges, input int tps,
                                  output logic [5:0] em, output logic [5:0] es);
        int n;
        n = edges / tps;
`ifdef TIME_ELAPSED_SATURATE_EN
        if (n > 3599) n = 3599;
`endif
        em = 6'((n / 60) % 60);
        es = 6'(n % 60);
    endfunction

    task automatic expect_at(input string tag, input int at, input int tps);
        exp_t e;
        e.tag = tag;
        e.at  = at;
        e.tps = tps;
        model(at, tps, e.mm, e.ss);
        sb.push_back(e);
    endtask

    task automatic check_now(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed mm:ss=%0d:%0d expected %0d:%0d",
                   tag, obs[11:6], obs[5:0], exp[11:6], exp[5:0]);
        end
    endtask

    task automatic run(input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            edge_cnt++;
            while (sb.size() > 0 && sb[0].at <= edge_cnt) begin
                e = sb.pop_front();
                if (e.at != edge_cnt) begin
                    check_now({e.tag, "_missed"}, 12'hfff, {e.mm, e.ss});
                end else if (e.tps == 4) begin
                    check_now(e.tag, {mm4, ss4}, {e.mm, e.ss});
                end else begin
                    check_now(e.tag, {mm1, ss1}, {e.mm, e.ss});
                end
            end
        end
    endtask

    // Called just after a sampled edge: rst high for 3 ns, well clear of the next edge.
    task automatic pulse_reset(input string tag);
        #1 rst = 1'b1;
        #1;
        check_now({tag, "_async4"}, {mm4, ss4}, 12'd0);
        check_now({tag, "_async1"}, {mm1, ss1}, 12'd0);
        #2 rst = 1'b0;
        edge_cnt = 0;
    endtask

    initial begin
        rst = 1'b1;
        #1;
        check_now("reset_noclk4", {mm4, ss4}, 12'd0);
        check_now("reset_noclk1", {mm1, ss1}, 12'd0);
        #1 rst = 1'b0;

        expect_at("tps1_edge1", 1, 1);
        expect_at("tps4_edge3", 3, 4);
        expect_at("tps4_edge4", 4, 4);
        expect_at("tps1_edge61", 61, 1);
        expect_at("tps4_edge236", 236, 4);
        expect_at("tps4_edge240", 240, 4);
        expect_at("tps4_edge14396", 14396, 4);
        expect_at("tps4_edge14400", 14400, 4);
        expect_at("tps1_edge14400", 14400, 1);
        expect_at("tps4_edge20000", 20000, 4);
        run(20000);

        pulse_reset("rst_a");
        expect_at("tps4_2m17s", 548, 4);
        run(548);

        pulse_reset("rst_b");
        expect_at("after_rst_edge3", 3, 4);
        expect_at("after_rst_edge4", 4, 4);
        expect_at("after_rst_edge5", 5, 4);
        run(5);

        if (sb.size() != 0) begin
            check_now("scoreboard_drain", 12'(sb.size()), 12'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: bench did not finish, observed edge_cnt=%0d", edge_cnt);
        $fatal(1, "timeout");
    end

endmodule
